serial_adder_ctrl: RTL

//  Bit-serial adder controller. Accepts two WIDTH-bit operands plus carry-in on a

---
 rtl/serial_adder_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder controller, LSB-first, one bit per clock,
//               registered sum/cout with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                 C_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_psum;
    logic [WIDTH-1:0]   w_psum_next;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_carry;
    logic [C_CNT_W-1:0] r_cnt;
    logic               w_s;
    logic               w_carry_next;
    logic               w_last;

    assign w_s          = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_next = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_last       = (r_cnt == C_LAST);

    // New sum bit enters at the MSB so after WIDTH shifts the word is aligned.
    generate
        if (WIDTH == 1) begin : g_psum_w1
            assign w_psum_next = w_s;
        end else begin : g_psum_wn
            assign w_psum_next = {w_s, r_psum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_ADD;
            S_ADD:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_ADD:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                S_ADD: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_carry_next;
                    r_psum  <= w_psum_next;
                    r_cnt   <= r_cnt + C_ONE;
                    // Result registers change only on the final bit.
                    if (w_last) begin
                        r_sum  <= w_psum_next;
                        r_cout <= w_carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire
